// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM state encodings and op-decode helpers for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Conditional two's-complement negation: yields the magnitude of a signed operand,
// or re-applies a sign to an unsigned result.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Define MULDIV_DIV_EN to build the divider; otherwise div/divu complete at once with op_err.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             op_err
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [WIDTH-1:0]   r_hi_acc, r_lo_acc, r_a_mag;
  logic               r_neg_q;
  logic               w_sgn, w_last;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_sgn     = op_is_signed(op);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  // r_a_mag holds the multiplicand for mult and the divisor for div.
  assign w_mul_sum = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_a_mag} : '0);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
    .i_val(src_a), .i_neg(w_sgn & src_a[WIDTH-1]), .o_val(w_a_mag));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
    .i_val(src_b), .i_neg(w_sgn & src_b[WIDTH-1]), .o_val(w_b_mag));
  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_val({r_hi_acc, r_lo_acc}), .i_neg(r_neg_q), .o_val(w_prod_fix));

`ifdef MULDIV_DIV_EN
  logic             r_is_div, r_neg_r, r_b_zero, r_dbz;
  logic [WIDTH-1:0] r_src_a;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff, w_rem_fix, w_quo_fix;
  logic             w_ge;

  assign w_shift = {r_hi_acc, r_lo_acc[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_a_mag});
  // Partial remainder stays below the divisor, so W bits hold the difference.
  assign w_diff  = w_shift[WIDTH-1:0] - r_a_mag;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .i_val(r_hi_acc), .i_neg(r_neg_r), .o_val(w_rem_fix));
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .i_val(r_lo_acc), .i_neg(r_neg_q), .o_val(w_quo_fix));

  assign div_by_zero = (r_state == DONE) && r_dbz;
  assign op_err      = 1'b0;
`else
  logic r_op_err;

  assign div_by_zero = 1'b0;
  assign op_err      = (r_state == DONE) && r_op_err;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          w_next = CALC;
`else
          w_next = op_is_div(op) ? DONE : CALC;
`endif
        end
      end
      CALC:    if (w_last) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
`ifdef MULDIV_DIV_EN
      r_dbz <= 1'b0;
`else
      r_op_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_cnt    <= '0;
            r_hi_acc <= '0;
            r_neg_q  <= w_sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            r_is_div <= op_is_div(op);
            r_neg_r  <= w_sgn & src_a[WIDTH-1];
            r_b_zero <= (src_b == '0);
            r_src_a  <= src_a;
            r_dbz    <= 1'b0;
            r_a_mag  <= op_is_div(op) ? w_b_mag : w_a_mag;
            r_lo_acc <= op_is_div(op) ? w_a_mag : w_b_mag;
`else
            r_op_err <= op_is_div(op);
            r_a_mag  <= w_a_mag;
            r_lo_acc <= w_b_mag;
`endif
          end
        end
        CALC: begin
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
`ifdef MULDIV_DIV_EN
          if (r_is_div) begin
            r_hi_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_lo_acc <= {r_lo_acc[WIDTH-2:0], w_ge};
          end else begin
            r_hi_acc <= w_mul_sum[WIDTH:1];
            r_lo_acc <= {w_mul_sum[0], r_lo_acc[WIDTH-1:1]};
          end
`else
          r_hi_acc <= w_mul_sum[WIDTH:1];
          r_lo_acc <= {w_mul_sum[0], r_lo_acc[WIDTH-1:1]};
`endif
        end
        FIX: begin
`ifdef MULDIV_DIV_EN
          if (r_is_div && r_b_zero) begin
            r_hi  <= r_src_a;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
`else
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == CALC) || (r_state == FIX);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32; divide vectors run when MULDIV_DIV_EN is defined.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done, div_by_zero, op_err;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  int lat, nbusy, ndone;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble operands to show they were latched.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0001; op = MD_DIVU;
  endtask

  task automatic wait_done(input int lat0, output int l, output int nb);
    l = lat0; nb = 0;
    while (!done && l < 100) begin
      if (busy) nb++;
      tick();
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    launch(o, a, b);
    wait_done(1, lat, nbusy);
    check({tag, " latency"}, lat, 34);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " div_by_zero"}, div_by_zero, exp_dbz);
    check({tag, " op_err"}, op_err, 0);
    tick();
    check({tag, " done one cycle"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = MD_MULT; src_a = '0; src_b = '0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset dbz", div_by_zero, 0);
    check("reset op_err", op_err, 0);

    // mthi in IDLE
    hi_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    hi_we = 1'b0;
    check("mthi", hi, 32'h0000_1234);

    // mult -3 * 5 with latency and busy window
    launch(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult busy first", busy, 1);
    wait_done(1, lat, nbusy);
    check("mult latency", lat, 34);
    check("mult busy cycles", nbusy, 33);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFF1);
    check("mult op_err", op_err, 0);
    tick();
    check("mult done pulse", done, 0);
    check("mult busy after", busy, 0);

    run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    // start and mtlo in the same IDLE cycle: write lands, result overwrites
    lo_we = 1'b1; wdata = 32'd55;
    launch(MD_MULT, 32'd2, 32'd3);
    check("same-cycle lo write", lo, 32'd55);
    wait_done(1, lat, nbusy);
    check("same-cycle latency", lat, 34);
    check("same-cycle lo result", lo, 32'd6);
    check("same-cycle hi result", hi, 0);
    tick();

    // start and mthi during CALC are ignored; start in DONE is ignored too
    launch(MD_MULT, 32'd7, 32'd9);
    repeat (4) tick();
    start = 1'b1; op = MD_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    hi_we = 1'b1; wdata = 32'h0000_AAAA;
    tick();
    start = 1'b0; hi_we = 1'b0;
    wait_done(6, lat, nbusy);
    check("ignored start latency", lat, 34);
    check("ignored start hi", hi, 0);
    check("ignored start lo", lo, 32'd63);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start in DONE ignored", busy, 0);

    // reset mid-operation dominates start and writes
    launch(MD_MULT, 32'd3, 32'd3);
    repeat (8) tick();
    reset = 1'b1; start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_5555;
    tick();
    reset = 1'b0; start = 1'b0; hi_we = 1'b0;
    check("mid reset busy", busy, 0);
    check("mid reset hi", hi, 0);
    check("mid reset lo", lo, 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) ndone++;
      tick();
    end
    check("mid reset no done", ndone, 0);

`ifdef MULDIV_DIV_EN
    run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu big", MD_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
    run_op("divu 7/0", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
    check("dbz cleared", div_by_zero, 0);
`else
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_AAAA;
    tick();
    lo_we = 1'b0; hi_we = 1'b0;
    launch(MD_DIVU, 32'd9, 32'd3);
    wait_done(1, lat, nbusy);
    check("nodiv latency", lat, 1);
    check("nodiv op_err", op_err, 1);
    check("nodiv dbz", div_by_zero, 0);
    check("nodiv hi", hi, 32'h0000_AAAA);
    check("nodiv lo", lo, 32'h0000_AAAA);
    tick();
    check("nodiv op_err after", op_err, 0);
    run_op("nodiv mult 2*3", MD_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
`endif

    // mthi back in IDLE after all operations
    hi_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    hi_we = 1'b0;
    check("mthi final", hi, 32'h0000_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
